cp0_interrupt_ctrl: RTL

- Coprocessor-0 interrupt controller for the 5-stage pipeline.
- Captures the three external interrupt lines, applies the mask and global-disable registers, and selects the highest-priority request.
- Takes the interrupt at the MEM-stage instruction boundary: saves EPC, flushes IF/ID/EX/MEM, redirects the PC to the handler entrance.
- Also sequences ERET and serves mtc0/mfc0 accesses to EPC (0x0e), disable (0x16) and mask (0x17).

---
 rtl/cp0_interrupt_ctrl_if.sv | 28 ++
 rtl/cp0_interrupt_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cp0_interrupt_ctrl_if.sv
// Pipeline <-> CP0 interrupt controller bundle: MEM-stage inputs, cp0 access, redirect/flush outputs.
interface cp0_interrupt_ctrl_if;
    logic [2:0]  irq_in;
    logic        mem_valid;
    logic [31:0] pc_next_mem;
    logic        eret_mem;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [2:0]  irq_ack;
    logic        int_disable;
    logic [2:0]  int_mask;
    logic [31:0] epc;

    modport master (
        output irq_in, mem_valid, pc_next_mem, eret_mem, mtc0_we, cp0_addr, cp0_wdata,
        input  cp0_rdata, redirect, redirect_pc, flush, irq_ack, int_disable, int_mask, epc
    );

    modport slave (
        input  irq_in, mem_valid, pc_next_mem, eret_mem, mtc0_we, cp0_addr, cp0_wdata,
        output cp0_rdata, redirect, redirect_pc, flush, irq_ack, int_disable, int_mask, epc
    );
endinterface

// File: rtl/cp0_interrupt_ctrl.sv
// CP0 interrupt controller: edge capture, mask/disable, priority take at MEM, ERET, mtc0/mfc0.
// Optional macro CP0_CAUSE_EN adds a read-only cause register at cp0 0x0d.
module cp0_interrupt_ctrl #(
    parameter logic [31:0] ENTRY2        = 32'h0000_0000,
    parameter logic [31:0] ENTRY1        = 32'h0000_0600,
    parameter logic [31:0] ENTRY0        = 32'h0000_0800,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    cp0_interrupt_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);
    localparam logic [4:0] ADDR_EPC  = 5'h0e;
    localparam logic [4:0] ADDR_DIS  = 5'h16;
    localparam logic [4:0] ADDR_MASK = 5'h17;
`ifdef CP0_CAUSE_EN
    localparam logic [4:0] ADDR_CAUSE = 5'h0d;
`endif

    typedef enum logic {S_IDLE, S_SETTLE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_pending, w_pending_nxt, w_pending_clr;
    logic [2:0]       r_irq_prev;
    logic             r_redirect, w_redirect_nxt;
    logic [31:0]      r_redirect_pc, w_redirect_pc_nxt;
    logic             r_flush, w_flush_nxt;
    logic [2:0]       r_irq_ack, w_irq_ack_nxt;
    logic             r_int_disable, w_int_disable_nxt;
    logic [2:0]       r_int_mask, w_int_mask_nxt;
    logic [31:0]      r_epc, w_epc_nxt;
    logic [2:0]       w_eligible;
    logic [1:0]       w_sel;
    logic [31:0]      w_entry;
    logic [31:0]      w_rdata;
`ifdef CP0_CAUSE_EN
    logic [1:0]       r_last_taken, w_last_taken_nxt;
`endif

    // Priority select among eligible lines, highest index wins
    always_comb begin
        w_eligible = r_pending & r_int_mask & {3{~r_int_disable}};
        w_sel      = 2'd0;
        w_entry    = ENTRY0;
        if (w_eligible[2]) begin
            w_sel   = 2'd2;
            w_entry = ENTRY2;
        end else if (w_eligible[1]) begin
            w_sel   = 2'd1;
            w_entry = ENTRY1;
        end
    end

    // Next-state logic; hardware epc/disable updates override a coincident mtc0
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_redirect_nxt    = 1'b0;
        w_flush_nxt       = 1'b0;
        w_irq_ack_nxt     = 3'b000;
        w_redirect_pc_nxt = r_redirect_pc;
        w_epc_nxt         = r_epc;
        w_int_disable_nxt = r_int_disable;
        w_int_mask_nxt    = r_int_mask;
        w_pending_clr     = 3'b000;
`ifdef CP0_CAUSE_EN
        w_last_taken_nxt  = r_last_taken;
`endif

        if (bus.mtc0_we) begin
            case (bus.cp0_addr)
                ADDR_EPC:  w_epc_nxt         = bus.cp0_wdata;
                ADDR_DIS:  w_int_disable_nxt = bus.cp0_wdata[0];
                ADDR_MASK: w_int_mask_nxt    = bus.cp0_wdata[2:0];
                default:   ;
            endcase
        end

        case (r_state)
            S_IDLE: begin
                if (bus.mem_valid && bus.eret_mem) begin
                    w_redirect_nxt    = 1'b1;
                    w_redirect_pc_nxt = r_epc;
                    w_flush_nxt       = 1'b1;
                    w_int_disable_nxt = 1'b0;
                    w_cnt_nxt         = SETTLE_INIT;
                    w_state_nxt       = S_SETTLE;
                end else if (bus.mem_valid && (|w_eligible)) begin
                    w_epc_nxt         = bus.pc_next_mem;
                    w_int_disable_nxt = 1'b1;
                    w_pending_clr     = 3'b001 << w_sel;
                    w_irq_ack_nxt     = 3'b001 << w_sel;
                    w_redirect_nxt    = 1'b1;
                    w_redirect_pc_nxt = w_entry;
                    w_flush_nxt       = 1'b1;
                    w_cnt_nxt         = SETTLE_INIT;
                    w_state_nxt       = S_SETTLE;
`ifdef CP0_CAUSE_EN
                    w_last_taken_nxt  = w_sel;
`endif
                end
            end
            S_SETTLE: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A new edge on a line being taken in the same cycle keeps it pending
        w_pending_nxt = (r_pending & ~w_pending_clr) | (bus.irq_in & ~r_irq_prev);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_pending     <= 3'b000;
            r_irq_prev    <= 3'b000;
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'h0;
            r_flush       <= 1'b0;
            r_irq_ack     <= 3'b000;
            r_int_disable <= 1'b0;
            r_int_mask    <= 3'b000;
            r_epc         <= 32'h0;
`ifdef CP0_CAUSE_EN
            r_last_taken  <= 2'd0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pending     <= w_pending_nxt;
            r_irq_prev    <= bus.irq_in;
            r_redirect    <= w_redirect_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_flush       <= w_flush_nxt;
            r_irq_ack     <= w_irq_ack_nxt;
            r_int_disable <= w_int_disable_nxt;
            r_int_mask    <= w_int_mask_nxt;
            r_epc         <= w_epc_nxt;
`ifdef CP0_CAUSE_EN
            r_last_taken  <= w_last_taken_nxt;
`endif
        end
    end

    // mfc0 read mux
    always_comb begin
        case (bus.cp0_addr)
            ADDR_EPC:   w_rdata = r_epc;
            ADDR_DIS:   w_rdata = {31'b0, r_int_disable};
            ADDR_MASK:  w_rdata = {29'b0, r_int_mask};
`ifdef CP0_CAUSE_EN
            ADDR_CAUSE: w_rdata = {26'b0, r_last_taken, 1'b0, r_pending};
`endif
            default:    w_rdata = 32'h0;
        endcase
    end

    assign bus.cp0_rdata   = w_rdata;
    assign bus.redirect    = r_redirect;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.flush       = r_flush;
    assign bus.irq_ack     = r_irq_ack;
    assign bus.int_disable = r_int_disable;
    assign bus.int_mask    = r_int_mask;
    assign bus.epc         = r_epc;
endmodule
